// File: rtl/tick_receiver_if.sv
// tick_receiver_if: groups the slow-wave input, controls and tick/period outputs of tick_receiver
// master drives slow_in/enable/clear; slave (the receiver) drives tick, ms_count, period,
// period_valid, locked, stalled.
interface tick_receiver_if #(
  parameter int CNT_W = 16,
  parameter int PER_W = 20
);
  logic             slow_in;
  logic             enable;
  logic             clear;
  logic             tick;
  logic [CNT_W-1:0] ms_count;
  logic [PER_W-1:0] period;
  logic             period_valid;
  logic             locked;
  logic             stalled;
  modport master (
    output slow_in, enable, clear,
    input  tick, ms_count, period, period_valid, locked, stalled
  );
  modport slave (
    input  slow_in, enable, clear,
    output tick, ms_count, period, period_valid, locked, stalled
  );
endinterface

// File: rtl/tick_receiver.sv
// tick_receiver: synchronises a slow square wave, emits one tick per rising edge, counts ticks
// Ports: clk, rst (sync, active-high); bus (slave): slow_in/enable/clear in,
// tick/ms_count/period/period_valid/locked/stalled out.
// TICK_RX_PERIOD_EN builds the edge-to-edge period capture; otherwise period/period_valid are 0.
module tick_receiver #(
  parameter int CNT_W   = 16,
  parameter int PER_W   = 20,
  parameter int TIMEOUT = 150_000
) (
  input logic            clk,
  input logic            rst,
  tick_receiver_if.slave bus
);
  typedef enum logic [1:0] {IDLE, LOCKED, STALLED} state_t;
  localparam logic [PER_W-1:0] STALL_AT = PER_W'(TIMEOUT - 1);
  logic [2:0]       sync_q;
  logic [1:0]       fill_q;
  logic             armed_q, armed_d;
  logic             rise, go;
  state_t           state_q, state_d;
  logic [PER_W-1:0] gap_q, gap_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick_q, tick_d, locked_q, stalled_q;
  // Reset zeroes the synchroniser, so a genuine low sample of slow_in must pass through
  // before edges are believed; fill_q marks which stages hold real samples.
  always_comb begin
    armed_d = armed_q | (fill_q[1] & ~sync_q[1]);
    rise    = sync_q[1] & ~sync_q[2] & armed_q;
    go      = rise & bus.enable & ~bus.clear;
    gap_d   = (!bus.enable || rise) ? '0 : (&gap_q ? gap_q : gap_q + 1'b1);
    tick_d  = go;
    cnt_d   = bus.clear ? '0 : cnt_q + CNT_W'(go);
    state_d = (!bus.enable || bus.clear) ? IDLE :
              rise ? LOCKED :
              (state_q == LOCKED && gap_q == STALL_AT) ? STALLED : state_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q    <= '0;
      fill_q    <= '0;
      armed_q   <= 1'b0;
      gap_q     <= '0;
      cnt_q     <= '0;
      tick_q    <= 1'b0;
      state_q   <= IDLE;
      locked_q  <= 1'b0;
      stalled_q <= 1'b0;
    end else begin
      sync_q    <= {sync_q[1:0], bus.slow_in};
      fill_q    <= {fill_q[0], 1'b1};
      armed_q   <= armed_d;
      gap_q     <= gap_d;
      cnt_q     <= cnt_d;
      tick_q    <= tick_d;
      state_q   <= state_d;
      locked_q  <= state_d == LOCKED;
      stalled_q <= state_d == STALLED;
    end
  end
`ifdef TICK_RX_PERIOD_EN
  logic [PER_W-1:0] period_q, period_d;
  logic             pv_q, pv_d;
  always_comb begin
    pv_d     = go & (state_q == LOCKED);
    period_d = bus.clear ? '0 : (pv_d ? gap_q + 1'b1 : period_q);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      period_q <= '0;
      pv_q     <= 1'b0;
    end else begin
      period_q <= period_d;
      pv_q     <= pv_d;
    end
  end
  assign bus.period       = period_q;
  assign bus.period_valid = pv_q;
`else
  assign bus.period       = '0;
  assign bus.period_valid = 1'b0;
`endif
  assign bus.tick     = tick_q;
  assign bus.ms_count = cnt_q;
  assign bus.locked   = locked_q;
  assign bus.stalled  = stalled_q;
endmodule

// File: tb/tb_tick_receiver.sv
// tb_tick_receiver: directed checks of tick_receiver with a 20-cycle wave and TIMEOUT=40
module tb_tick_receiver;
  localparam int CNT_W = 4;
  localparam int PER_W = 20;
`ifdef TICK_RX_PERIOD_EN
  localparam bit PEN = 1'b1;
`else
  localparam bit PEN = 1'b0;
`endif
  localparam logic [31:0] P20 = PEN ? 32'd20 : 32'd0;
  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad = 0;
  logic c_tick, c_pv, c_lock, c_stall, n_tick;
  logic [PER_W-1:0] c_per;
  logic [CNT_W-1:0] c_cnt;
  tick_receiver_if #(.CNT_W(CNT_W), .PER_W(PER_W)) bus ();
  tick_receiver #(.CNT_W(CNT_W), .PER_W(PER_W), .TIMEOUT(40)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  // one 20-cycle period: 10 high, 10 low; outputs captured where the tick should be high
  task automatic edge20();
    bus.slow_in = 1'b1;
    step(3);
    c_tick = bus.tick; c_pv = bus.period_valid; c_per = bus.period;
    c_lock = bus.locked; c_stall = bus.stalled; c_cnt = bus.ms_count;
    step(1);
    n_tick = bus.tick;
    step(6);
    bus.slow_in = 1'b0;
    step(10);
  endtask
  initial begin
    #200_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end
  initial begin
    rst = 1'b1; bus.slow_in = 1'b1; bus.enable = 1'b1; bus.clear = 1'b0;
    step(3);
    chk("rst_tick", bus.tick, 0);
    chk("rst_cnt", bus.ms_count, 0);
    chk("rst_per", bus.period, 0);
    chk("rst_pv", bus.period_valid, 0);
    chk("rst_lock", bus.locked, 0);
    chk("rst_stall", bus.stalled, 0);
    rst = 1'b0;
    step(6);
    chk("post_rst_cnt", bus.ms_count, 0);
    chk("post_rst_lock", bus.locked, 0);
    bus.slow_in = 1'b0;
    step(10);
    edge20();
    chk("e1_tick", c_tick, 1);
    chk("e1_lock", c_lock, 1);
    chk("e1_pv", c_pv, 0);
    chk("e1_cnt", c_cnt, 1);
    chk("e1_width", n_tick, 0);
    for (int i = 2; i <= 4; i++) begin
      edge20();
      chk("wave_tick", c_tick, 1);
      chk("wave_pv", c_pv, PEN);
      chk("wave_per", c_per, P20);
      chk("wave_cnt", c_cnt, i);
      chk("wave_pv_width", n_tick, 0);
    end
    step(22);
    chk("pre_stall", bus.stalled, 0);
    chk("pre_stall_lock", bus.locked, 1);
    step(1);
    chk("stall", bus.stalled, 1);
    chk("stall_lock", bus.locked, 0);
    step(5);
    edge20();
    chk("restart_tick", c_tick, 1);
    chk("restart_lock", c_lock, 1);
    chk("restart_stall", c_stall, 0);
    chk("restart_pv", c_pv, 0);
    chk("restart_per", c_per, P20);
    chk("restart_cnt", c_cnt, 5);
    for (int i = 0; i < 10; i++) edge20();
    chk("wrap_15", c_cnt, 15);
    edge20();
    chk("wrap_0", c_cnt, 0);
    edge20();
    chk("wrap_1", c_cnt, 1);
    chk("wrap_per", c_per, P20);
    bus.slow_in = 1'b1;
    step(2);
    bus.clear = 1'b1;
    step(1);
    bus.clear = 1'b0;
    chk("clr_tick", bus.tick, 0);
    chk("clr_cnt", bus.ms_count, 0);
    chk("clr_per", bus.period, 0);
    chk("clr_lock", bus.locked, 0);
    chk("clr_pv", bus.period_valid, 0);
    step(7);
    bus.slow_in = 1'b0;
    step(10);
    edge20();
    chk("clr_relock", c_lock, 1);
    chk("clr_relock_pv", c_pv, 0);
    chk("clr_relock_cnt", c_cnt, 1);
    edge20();
    chk("clr_next_pv", c_pv, PEN);
    chk("clr_next_per", c_per, P20);
    chk("clr_next_cnt", c_cnt, 2);
    bus.enable = 1'b0;
    step(1);
    chk("dis_lock", bus.locked, 0);
    for (int i = 0; i < 3; i++) begin
      edge20();
      chk("dis_tick", c_tick, 0);
      chk("dis_cnt", c_cnt, 2);
      chk("dis_lock_e", c_lock, 0);
    end
    bus.enable = 1'b1;
    edge20();
    chk("en_tick", c_tick, 1);
    chk("en_lock", c_lock, 1);
    chk("en_pv", c_pv, 0);
    chk("en_cnt", c_cnt, 3);
    edge20();
    chk("en_per", c_per, P20);
    chk("en_pv2", c_pv, PEN);
    chk("en_cnt2", c_cnt, 4);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/tick_receiver.md
# tick_receiver

Consumer end of the divided-clock path: samples a slow, free-running square wave (e.g. the 1 ms divider output) as an asynchronous data input in the fast `clk` domain. Synchronises it, converts each rising edge into a one-cycle `tick` strobe, and keeps a wrapping tick count. Optionally measures the edge-to-edge period in `clk` cycles. Watches for a stalled source. Game timing logic uses `tick`/`ms_count` instead of clocking flops from the slow signal directly.

## Interface
- `CNT_W`, default 16: width of `ms_count`.
- `PER_W`, default 20: width of the gap counter and `period`.
- `TIMEOUT`, default 150_000: number of `clk` cycles without a rising edge before declaring stall. Must satisfy 2 ≤ TIMEOUT < 2^PER_W.

Ports:
- `clk` in 1: system clock; all logic is on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `slow_in` in 1: slow square wave, asynchronous to `clk`.
- `enable` in 1: when low, edge processing is suspended.
- `clear` in 1: synchronous soft clear of count, period and FSM.
- `tick` out 1: one-cycle pulse per detected rising edge of `slow_in`.
- `ms_count` out CNT_W: number of ticks, wrapping.
- `period` out PER_W: last measured edge-to-edge interval, in `clk` cycles.
- `period_valid` out 1: one-cycle pulse when `period` updates.
- `locked` out 1: FSM is in LOCKED.
- `stalled` out 1: FSM is in STALLED.

## Operation
- **Synchroniser:** `s0 <= slow_in`, `s1 <= s0`, `s2 <= s1`. `rise = s1 & ~s2`. The synchroniser runs regardless of `enable` and `clear`.
- **Gap counter** (PER_W bits):
  - Zeroed in any cycle where `rise` is true.
  - Otherwise increments, saturating at 2^PER_W−1.
  - Held at 0 while `enable` is low.
- **FSM states:** IDLE, LOCKED, STALLED.
  - IDLE → LOCKED on `rise & enable`. No `period_valid` on this transition.
  - LOCKED → LOCKED on `rise`. `period <= gap+1`, `period_valid` pulses.
  - LOCKED → STALLED when the gap counter equals TIMEOUT−1 with no `rise` in the same cycle.
  - STALLED → LOCKED on `rise`. No `period_valid`; `period` is held.
  - Any state → IDLE when `enable` is low or `clear` is high.
- **tick:** registered. `tick <= rise & enable & ~clear`.
- **ms_count:** increments by 1 each cycle in which `tick` is registered high. Wraps from 2^CNT_W−1 to 0.
- **clear:**
  - Sets `ms_count` and `period` to 0 and the FSM to IDLE.
  - Suppresses `tick` and `period_valid` in that cycle.
  - `clear` wins over a simultaneous `rise`.
- **rst:** overrides `clear` and `enable`. Zeroes the synchroniser flops, counters and `period`; FSM goes to IDLE.
- **Reset values:** `tick`=0, `ms_count`=0, `period`=0, `period_valid`=0, `locked`=0, `stalled`=0.

## Timing
- **Latency:** `slow_in` first sampled high at clk edge k → `rise` true in cycle k+1 → `tick` high from edge k+2 to edge k+3. Both `period_valid` and `ms_count` update at edge k+2, coincident with `tick`.
- **Pulse width:** `tick` and `period_valid` are exactly one cycle wide.
- **Minimum input period:** a `slow_in` high or low phase shorter than 2 `clk` cycles is not guaranteed to be detected.
- **Period arithmetic:** for a square wave of period P cycles, steady-state `period` = P.
- **Stall timing:** `stalled` asserts at the edge where the gap counter would reach TIMEOUT, i.e. TIMEOUT cycles after the last `rise`.
- **Outputs:** `locked` and `stalled` are registered state decodes; they are never both high.
- **Reset mid-operation:** takes effect at the next clk edge. The first `rise` after reset requires `slow_in` to be sampled low, then high.

## Configuration
- `TICK_RX_PERIOD_EN`: when defined, period capture and `period_valid` are built as described above.
- When undefined:
  - `period` is tied to 0 and `period_valid` to 0.
  - The capture register is not built.
  - The gap counter, FSM, stall detection, `tick` and `ms_count` are unchanged.

## Test plan
- **Reset:** assert `rst` for 3 cycles with `slow_in`=1 → all outputs 0. After release, no `tick` until `slow_in` goes low then high.
- **Steady 20-cycle square wave**, `enable`=1, TIMEOUT=40 → `tick` every 20 cycles, 3 cycles after each rising sample. First edge: `locked`=1 with no `period_valid`. Second and later edges: `period`=20 with `period_valid` pulsing.
- **Stall:** stop `slow_in` low after an edge → `stalled`=1 exactly 40 cycles after the last `rise`. Restart the wave → next edge gives `locked`=1, `tick`=1, `period_valid`=0, and `period` still 20.
- **Wrap:** CNT_W=4, drive 17 edges → `ms_count` reads 15, then 0, then 1.
- **clear and rise in the same cycle** → no `tick`, `ms_count`=0, `period`=0, FSM IDLE. The next edge relocks without `period_valid`.
- **enable low for 3 edges** → no ticks, `ms_count` frozen, `locked`=0. Re-enable → first edge gives `locked`=1 with no `period_valid`; the second edge gives `period`=20.
